i2c_config_seq: RTL and testbench



---
 rtl/codec_cfg_pkg.sv | 38 +++
 rtl/codec_cfg_rom.sv | 20 ++
 rtl/i2c_config_seq.sv | 170 +++++++++++++++++
 tb/tb_i2c_config_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/codec_cfg_pkg.sv
// Shared types and the default WM8731 init table for the codec configuration sequencer.
// Table words are {reg_addr[6:0], reg_data[8:0]}; the sequencer prepends the device address.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    PWRUP, LOAD, ISSUE, WAIT_BUSY, WAIT_DONE, FAIL, GAP, IDLE
  } seq_state_t;

  typedef logic [15:0] cfg_word_t;

  localparam logic [6:0] REG_LLINVOL = 7'h00;
  localparam logic [6:0] REG_RLINVOL = 7'h01;
  localparam logic [6:0] REG_LHPOUT  = 7'h02;
  localparam logic [6:0] REG_RHPOUT  = 7'h03;
  localparam logic [6:0] REG_AAPCTRL = 7'h04;
  localparam logic [6:0] REG_DAPCTRL = 7'h05;
  localparam logic [6:0] REG_PWRDN   = 7'h06;
  localparam logic [6:0] REG_IFACE   = 7'h07;
  localparam logic [6:0] REG_ACTIVE  = 7'h09;
  localparam logic [6:0] REG_RESET   = 7'h0F;

  localparam int INIT_LEN = 10;

  // Reset first, power up, set levels and routing, activate the interface last.
  localparam cfg_word_t INIT_TABLE [0:INIT_LEN-1] = '{
    {REG_RESET,   9'h000},
    {REG_PWRDN,   9'h000},
    {REG_LLINVOL, 9'h017},
    {REG_RLINVOL, 9'h017},
    {REG_LHPOUT,  9'h079},
    {REG_RHPOUT,  9'h079},
    {REG_AAPCTRL, 9'h012},
    {REG_DAPCTRL, 9'h000},
    {REG_IFACE,   9'h042},
    {REG_ACTIVE,  9'h001}
  };

endpackage

// File: rtl/codec_cfg_rom.sv
// Combinational init-table lookup, idx -> cfg word; swap this module to retarget another codec.
// Indices beyond the table (or beyond NUM_REGS) read as zero.
module codec_cfg_rom
  import codec_cfg_pkg::*;
#(
  parameter int NUM_REGS = 10,
  parameter int IDX_W    = $clog2(NUM_REGS) + 1
) (
  input  logic [IDX_W-1:0] idx,
  output cfg_word_t        word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < INIT_LEN; i++) begin
      if (i < NUM_REGS && int'(idx) == i) word = INIT_TABLE[i];
    end
  end

endmodule

// File: rtl/i2c_config_seq.sv
// Drives the codec I2C write engine: power-up delay, init table with NACK/timeout retry, then host writes.
// One frame in flight at a time; host_req is held off (no host_gnt) until init is done and the engine is idle.
module i2c_config_seq
  import codec_cfg_pkg::*;
#(
  parameter int         NUM_REGS     = 10,
  parameter logic [7:0] DEV_ADDR     = 8'h34,
  parameter int         MAX_RETRY    = 3,
  parameter int         GAP_CYCLES   = 256,
  parameter int         PWRUP_CYCLES = 4096,
  parameter int         BUSY_TMO     = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        i2c_start,
  output logic [23:0] i2c_data,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  input  logic        host_req,
  input  logic [15:0] host_word,
  output logic        host_gnt,
  output logic        busy,
  output logic        init_done,
  output logic        cfg_err,
  output logic [3:0]  err_cnt
);

  localparam int IDX_W    = $clog2(NUM_REGS) + 1;
  localparam int RETRY_W  = $clog2(MAX_RETRY + 1) + 1;
  localparam int CNT_MAX0 = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > BUSY_TMO) ? CNT_MAX0 : BUSY_TMO;
  localparam int CNT_W    = $clog2(CNT_MAX) + 1;

  seq_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [RETRY_W-1:0] retry, retry_nxt;
  logic               again, again_nxt;
  logic [23:0]        data_nxt;
  logic               init_done_nxt, cfg_err_nxt;
  logic [3:0]         err_cnt_nxt;
  cfg_word_t          rom_word;

  codec_cfg_rom #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_rom (
    .idx  (idx),
    .word (rom_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PWRUP;
      cnt       <= '0;
      idx       <= '0;
      retry     <= '0;
      again     <= 1'b0;
      i2c_data  <= '0;
      init_done <= 1'b0;
      cfg_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      retry     <= retry_nxt;
      again     <= again_nxt;
      i2c_data  <= data_nxt;
      init_done <= init_done_nxt;
      cfg_err   <= cfg_err_nxt;
      err_cnt   <= err_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    retry_nxt     = retry;
    again_nxt     = again;
    data_nxt      = i2c_data;
    init_done_nxt = init_done;
    cfg_err_nxt   = cfg_err;
    err_cnt_nxt   = err_cnt;
    i2c_start     = 1'b0;
    host_gnt      = 1'b0;

    unique case (state)
      PWRUP: begin
        if (cnt == CNT_W'(PWRUP_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = LOAD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LOAD: begin
        data_nxt  = {DEV_ADDR, rom_word};
        retry_nxt = '0;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        if (i2c_done) begin
          i2c_start = 1'b1;
          cnt_nxt   = '0;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // An engine that never leaves idle counts as a failed attempt.
        if (!i2c_done) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CNT_W'(BUSY_TMO - 1)) begin
          state_nxt = FAIL;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (i2c_done) begin
          cnt_nxt   = '0;
          state_nxt = i2c_ack ? GAP : FAIL;
        end
      end
      FAIL: begin
        if (err_cnt != 4'hF) err_cnt_nxt = err_cnt + 4'd1;
        if (retry < RETRY_W'(MAX_RETRY)) begin
          retry_nxt = retry + 1'b1;
          again_nxt = 1'b1;
        end else begin
          cfg_err_nxt = 1'b1;
          again_nxt   = 1'b0;
        end
        cnt_nxt   = '0;
        state_nxt = GAP;
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_nxt = '0;
          if (again) begin
            again_nxt = 1'b0;
            state_nxt = ISSUE;
          end else if (init_done) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + 1'b1;
            if (idx_nxt < IDX_W'(NUM_REGS)) begin
              state_nxt = LOAD;
            end else begin
              init_done_nxt = 1'b1;
              state_nxt     = IDLE;
            end
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      IDLE: begin
        if (host_req) begin
          host_gnt  = 1'b1;
          data_nxt  = {DEV_ADDR, host_word};
          retry_nxt = '0;
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = PWRUP;
    endcase
  end

  assign busy = (state != IDLE) || host_gnt;

endmodule

// File: tb/tb_i2c_config_seq.sv
// Directed bench for i2c_config_seq with a behavioural I2C engine (NACK injection, stuck-idle mode).
// Expected frames and timings are hand-computed for NUM_REGS=4, PWRUP=16, GAP=8, BUSY_TMO=8, MAX_RETRY=3.
module tb_i2c_config_seq;

  localparam int FRAME_LEN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i2c_start;
  logic [23:0] i2c_data;
  logic        eng_done;
  logic        eng_ack;
  logic        host_req = 1'b0;
  logic [15:0] host_word = '0;
  logic        host_gnt;
  logic        busy;
  logic        init_done;
  logic        cfg_err;
  logic [3:0]  err_cnt;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  i2c_config_seq #(
    .NUM_REGS(4), .DEV_ADDR(8'h34), .MAX_RETRY(3),
    .GAP_CYCLES(8), .PWRUP_CYCLES(16), .BUSY_TMO(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i2c_start (i2c_start),
    .i2c_data  (i2c_data),
    .i2c_done  (eng_done),
    .i2c_ack   (eng_ack),
    .host_req  (host_req),
    .host_word (host_word),
    .host_gnt  (host_gnt),
    .busy      (busy),
    .init_done (init_done),
    .cfg_err   (cfg_err),
    .err_cnt   (err_cnt)
  );

  // Engine model: done low for FRAME_LEN cycles per start, NACKs nack_data the first nack_times starts.
  logic        stuck = 1'b0;
  logic [23:0] nack_data = '0;
  int          nack_times = 0;
  int          eng_rem, start_cnt, nack_seen;
  int          cyc = 0;
  logic [23:0] log_dat [0:63];
  int          log_cyc [0:63];
  int          gnt_cnt = 0;
  int          early_gnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      eng_done  <= 1'b1;
      eng_ack   <= 1'b0;
      eng_rem   <= 0;
      start_cnt <= 0;
      nack_seen <= 0;
    end else if (i2c_start) begin
      if (start_cnt < 64) begin
        log_dat[start_cnt] <= i2c_data;
        log_cyc[start_cnt] <= cyc;
      end
      start_cnt <= start_cnt + 1;
      if (!stuck) begin
        eng_done <= 1'b0;
        eng_rem  <= FRAME_LEN;
        if (i2c_data == nack_data && nack_seen < nack_times) begin
          eng_ack   <= 1'b0;
          nack_seen <= nack_seen + 1;
        end else begin
          eng_ack <= 1'b1;
        end
      end
    end else if (eng_rem > 0) begin
      eng_rem <= eng_rem - 1;
      if (eng_rem == 1) eng_done <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (host_gnt) gnt_cnt <= gnt_cnt + 1;
    if (host_gnt && !init_done) early_gnt <= early_gnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_start", i2c_start, 0);
    chk("rst_data", i2c_data, 0);
    chk("rst_busy", busy, 1);
    chk("rst_init_done", init_done, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget);
    int c = 0;
    while (start_cnt < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("wait_starts", start_cnt >= n, 1);
  endtask

  task automatic wait_init(input int budget);
    int c = 0;
    while (!init_done && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("wait_init", init_done, 1);
  endtask

  initial begin
    int nb;
    int c;
    int g0;

    // T1: clean init, 4 frames, frame spacing 1+(FRAME_LEN+1)+GAP+1 = 15 cycles.
    apply_reset();
    wait_starts(4, 500);
    chk("t1_init_before_last_gap", init_done, 0);
    wait_init(500);
    chk("t1_starts", start_cnt, 4);
    chk("t1_f0", log_dat[0], 24'h341E00);
    chk("t1_f1", log_dat[1], 24'h340C00);
    chk("t1_f2", log_dat[2], 24'h340017);
    chk("t1_f3", log_dat[3], 24'h340217);
    chk("t1_spacing", log_cyc[1] - log_cyc[0], 15);
    chk("t1_cfg_err", cfg_err, 0);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_idle", busy, 0);

    // T2: entry 2 NACKed once, retried with identical data.
    nack_data = 24'h340017; nack_times = 1;
    apply_reset();
    wait_init(1000);
    chk("t2_starts", start_cnt, 5);
    chk("t2_f2a", log_dat[2], 24'h340017);
    chk("t2_f2b", log_dat[3], 24'h340017);
    chk("t2_f3", log_dat[4], 24'h340217);
    chk("t2_err_cnt", err_cnt, 1);
    chk("t2_cfg_err", cfg_err, 0);

    // T3: entry 1 NACKed on all 4 attempts; later entries still sent.
    nack_data = 24'h340C00; nack_times = 4;
    apply_reset();
    wait_init(1500);
    chk("t3_starts", start_cnt, 7);
    chk("t3_f1_last", log_dat[4], 24'h340C00);
    chk("t3_f2", log_dat[5], 24'h340017);
    chk("t3_f3", log_dat[6], 24'h340217);
    chk("t3_cfg_err", cfg_err, 1);
    chk("t3_err_cnt", err_cnt, 4);

    // T4: engine never drops done; attempt spacing 1+BUSY_TMO+1+GAP = 18, 16 attempts, err_cnt saturates.
    nack_times = 0; stuck = 1'b1;
    apply_reset();
    wait_init(2000);
    chk("t4_starts", start_cnt, 16);
    chk("t4_tmo_spacing", log_cyc[1] - log_cyc[0], 18);
    chk("t4_f0_last", log_dat[3], 24'h341E00);
    chk("t4_f1_first", log_dat[4], 24'h340C00);
    chk("t4_cfg_err", cfg_err, 1);
    chk("t4_err_cnt", err_cnt, 15);
    stuck = 1'b0;

    // T5: host request held through init; one grant once init completes.
    apply_reset();
    g0 = gnt_cnt;
    host_word = 16'h0479; host_req = 1'b1;
    wait_init(500);
    chk("t5_no_early_gnt", early_gnt, 0);
    chk("t5_gnt_at_idle", host_gnt, 1);
    chk("t5_busy_gnt", busy, 1);
    @(posedge clk);
    #1 host_req = 1'b0;
    chk("t5_host_data", i2c_data, 24'h340479);
    nb = 1; c = 0;
    @(negedge clk);
    while (busy && c < 100) begin
      nb++; c++;
      @(negedge clk);
    end
    chk("t5_busy_cycles", nb, 15);
    chk("t5_gnt_once", gnt_cnt - g0, 1);
    chk("t5_starts", start_cnt, 5);
    chk("t5_frame", log_dat[4], 24'h340479);

    // T6: reset during WAIT_DONE of entry 2; sequence restarts from entry 0.
    nack_data = 24'h341E00; nack_times = 1;
    apply_reset();
    wait_starts(4, 500);
    @(negedge clk);
    chk("t6_err_before", err_cnt, 1);
    chk("t6_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_start", i2c_start, 0);
    chk("t6_data", i2c_data, 0);
    chk("t6_gnt", host_gnt, 0);
    chk("t6_busy", busy, 1);
    chk("t6_init_done", init_done, 0);
    chk("t6_cfg_err", cfg_err, 0);
    chk("t6_err_cnt", err_cnt, 0);
    rst = 1'b0;
    wait_starts(1, 200);
    chk("t6_restart_f0", log_dat[0], 24'h341E00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
